// File: rtl/video_pkg.sv
// Shared video constants: colour width, 640x480 visible area and colour-bar table.
package video_pkg;

  localparam int COLOR_W   = 12;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int BAR_W     = 80;
  localparam int NUM_BARS  = H_VISIBLE / BAR_W;

  // {r,g,b} full-intensity enables, index 0 = leftmost bar
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b111,  // white
    3'b110,  // yellow
    3'b101,  // magenta
    3'b100,  // red
    3'b011,  // cyan
    3'b010,  // green
    3'b001,  // blue
    3'b000   // black
  };

endpackage

// File: rtl/layer_mux.sv
// Combinational compositor: lowest-index visible layer wins, else background; blanked outside video.
// Colour bars replace the composite when VIDEO_OUT_TEST_PATTERN_EN is defined and test_mode_i=1.
module layer_mux #(
  parameter int                    NUM_LAYERS = 4,
  parameter int                    COLOR_W    = video_pkg::COLOR_W,
  parameter logic [NUM_LAYERS-1:0] BLINK_MASK = '0
) (
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]         layer_valid_i,
  input  logic [COLOR_W-1:0]            bg_rgb_i,
  input  logic                          video_on_i,
  input  logic                          blink_phase_i,
  input  logic                          test_mode_i,
  input  logic [9:0]                    x_i,
  output logic [COLOR_W-1:0]            pix_o
);
  import video_pkg::*;

  logic [COLOR_W-1:0] comp;

  always_comb begin
    comp = bg_rgb_i;
    // walk high to low so the lowest qualifying index is the last assignment
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid_i[i] && !(BLINK_MASK[i] && blink_phase_i))
        comp = layer_rgb_i[i*COLOR_W +: COLOR_W];
    end
  end

`ifdef VIDEO_OUT_TEST_PATTERN_EN
  localparam int CW = COLOR_W / 3;

  logic [2:0]         bar_sel;
  logic [2:0]         bar_en;
  logic [COLOR_W-1:0] bar_pix;

  always_comb begin
    bar_sel = (x_i >= 10'(H_VISIBLE)) ? 3'(NUM_BARS - 1) : 3'(x_i / 10'(BAR_W));
    bar_en  = BAR_TABLE[bar_sel];
    bar_pix = COLOR_W'({{CW{bar_en[2]}}, {CW{bar_en[1]}}, {CW{bar_en[0]}}});
  end

  always_comb begin
    pix_o = test_mode_i ? bar_pix : comp;
    if (!video_on_i) pix_o = '0;
  end
`else
  logic unused_tp;
  assign unused_tp = ^{test_mode_i, x_i};

  always_comb begin
    pix_o = comp;
    if (!video_on_i) pix_o = '0;
  end
`endif

endmodule

// File: rtl/video_out_stage.sv
// Video output stage: layer compositing, PIPE_DEPTH p_tick-gated pixel/sync pipeline, frame counter.
// Optional colour bars via macro VIDEO_OUT_TEST_PATTERN_EN (see layer_mux).
module video_out_stage #(
  parameter int                    NUM_LAYERS  = 4,
  parameter int                    COLOR_W     = video_pkg::COLOR_W,
  parameter int                    PIPE_DEPTH  = 2,
  parameter logic                  SYNC_IDLE   = 1'b0,
  parameter logic [NUM_LAYERS-1:0] BLINK_MASK  = '0,
  parameter int                    BLINK_SHIFT = 5
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          p_tick,
  input  logic                          video_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [9:0]                    x,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic                          test_mode,
  output logic                          hsync,
  output logic                          vsync,
  output logic [COLOR_W-1:0]            rgb,
  output logic [7:0]                    frame_cnt
);

  logic [PIPE_DEPTH-1:0][COLOR_W-1:0] rgb_q;
  logic [PIPE_DEPTH-1:0]              hs_q;
  logic [PIPE_DEPTH-1:0]              vs_q;
  logic                               vs_prev_q;
  logic [7:0]                         frame_cnt_q;
  logic [7:0]                         frame_cnt_d;
  logic [COLOR_W-1:0]                 comp;

  layer_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W),
    .BLINK_MASK (BLINK_MASK)
  ) u_layer_mux (
    .layer_rgb_i   (layer_rgb),
    .layer_valid_i (layer_valid),
    .bg_rgb_i      (bg_rgb),
    .video_on_i    (video_on),
    .blink_phase_i (frame_cnt_q[BLINK_SHIFT]),
    .test_mode_i   (test_mode),
    .x_i           (x),
    .pix_o         (comp)
  );

  // count only rising edges of vsync as seen on pixel ticks
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vsync_in && !vs_prev_q) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rgb_q       <= '0;
      hs_q        <= {PIPE_DEPTH{SYNC_IDLE}};
      vs_q        <= {PIPE_DEPTH{SYNC_IDLE}};
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else if (p_tick) begin
      rgb_q[0] <= comp;
      hs_q[0]  <= hsync_in;
      vs_q[0]  <= vsync_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        rgb_q[k] <= rgb_q[k-1];
        hs_q[k]  <= hs_q[k-1];
        vs_q[k]  <= vs_q[k-1];
      end
      vs_prev_q   <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rgb       = rgb_q[PIPE_DEPTH-1];
  assign hsync     = hs_q[PIPE_DEPTH-1];
  assign vsync     = vs_q[PIPE_DEPTH-1];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/video_out_stage.md
VIDEO_OUT_STAGE -- requirements
Module: video_out_stage

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4: overlay layer count, 1..8.
REQ-002 SHALL have parameter COLOR_W, default 12: rgb width, 4-4-4 packed {r,g,b}.
REQ-003 SHALL have parameter PIPE_DEPTH, default 2: pixel-tick pipeline stages, 1..4.
REQ-004 SHALL have parameter SYNC_IDLE, default 1'b0: hsync/vsync level driven during reset.
REQ-005 SHALL have parameter BLINK_MASK, default 0 (NUM_LAYERS bits): layers that blink.
REQ-006 SHALL have parameter BLINK_SHIFT, default 5: frame-counter bit gating blink.
REQ-007 SHALL have port clk_100MHz, input, 1: single clock. Everything is synchronous to its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port p_tick, input, 1: pixel-enable strobe, one clk_100MHz cycle wide.
REQ-010 SHALL have port video_on, input, 1: visible-area flag from the VGA timing block.
REQ-011 SHALL have ports hsync_in and vsync_in, input, 1 each: raw syncs.
REQ-012 SHALL have port x, input, 10: current pixel column.
REQ-013 SHALL have port layer_rgb, input, NUM_LAYERS*COLOR_W: layer i occupies bits [i*COLOR_W +: COLOR_W].
REQ-014 SHALL have port layer_valid, input, NUM_LAYERS: layer i owns the current pixel.
REQ-015 SHALL have port bg_rgb, input, COLOR_W: background colour.
REQ-016 SHALL have port test_mode, input, 1: selects colour bars (see Configuration).
REQ-017 SHALL have ports hsync and vsync, output, 1 each: delay-aligned syncs.
REQ-018 SHALL have port rgb, output, COLOR_W: registered pixel.
REQ-019 SHALL have port frame_cnt, output, 8: frame counter.

Function
REQ-020 SHALL composite each pixel from the lowest index i with layer_valid[i]=1 and effective visibility; bg_rgb when no layer qualifies.
REQ-021 SHALL treat layer i as invisible when BLINK_MASK[i]=1 and frame_cnt[BLINK_SHIFT]=1.
REQ-022 SHALL force the composited pixel to 0 when video_on=0, regardless of layers.
REQ-023 SHALL capture {composite, hsync_in, vsync_in} into stage 0 only on cycles with p_tick=1.
REQ-024 SHALL shift stage k-1 into stage k only on cycles with p_tick=1; all stages hold otherwise.
REQ-025 SHALL drive rgb, hsync and vsync from stage PIPE_DEPTH-1, giving a latency of exactly PIPE_DEPTH p_ticks, and all three SHALL remain aligned.
REQ-026 SHALL increment frame_cnt by 1, wrapping 255 to 0, on each p_tick cycle where vsync_in=1 and the previous p_tick-sampled vsync_in was 0.
REQ-027 SHALL ignore p_tick on a cycle where reset=1; reset has priority.

Reset
REQ-028 SHALL, while reset=1 (synchronous), clear every rgb stage to 0, set every sync stage to SYNC_IDLE, clear frame_cnt and the vsync history to 0.
REQ-029 SHALL, after reset deasserts mid-frame, output 0/SYNC_IDLE until PIPE_DEPTH p_ticks have flushed the pipeline.

Configuration
REQ-030 SHALL, when macro VIDEO_OUT_TEST_PATTERN_EN is defined and test_mode=1, replace the layer/background composite with 8 vertical bars 80 px wide.
REQ-031 SHALL index the bars by x/80 in the order black, blue, green, cyan, red, magenta, yellow, white, at full component intensity; REQ-022 blanking still applies.
REQ-032 SHALL, when VIDEO_OUT_TEST_PATTERN_EN is undefined, ignore test_mode and contain no bar logic.

Structure
REQ-033 SHALL take COLOR_W, the 640x480 visible constants, the bar width (80) and the bar colour table from shared package video_pkg.
REQ-034 SHALL implement the compositor as combinational sub-module layer_mux; the pipeline and frame counter stay in video_out_stage.

Verification
REQ-035 SHALL cover: PIPE_DEPTH=2, layer_valid=4'b0110, layer1=12'hF00, layer2=12'h0F0, video_on=1 -> rgb=12'hF00 two p_ticks later.
REQ-036 SHALL cover: layer_valid=0, bg_rgb=12'h00F, then video_on=0 -> rgb=12'h00F, then 12'h000; hsync toggles with the same latency.
REQ-037 SHALL cover: p_tick held low for 10 cycles while inputs change -> rgb, hsync, vsync and frame_cnt unchanged.
REQ-038 SHALL cover: 32 vsync rising edges with BLINK_MASK=4'b0001, only layer0 valid=12'hFFF -> frame_cnt=32, rgb=bg_rgb; after 32 more edges frame_cnt=64, rgb=12'hFFF.
REQ-039 SHALL cover: reset asserted for one cycle mid-line with p_tick=1 -> next cycle rgb=0, syncs=SYNC_IDLE, frame_cnt=0.
REQ-040 SHALL cover: macro defined, test_mode=1, x=85 -> rgb=12'h00F; x=639 -> rgb=12'hFFF.
